// File: rtl/csr_mtrap_file.sv
// csr_mtrap_file: M-mode CSR file with trap entry / mret sequencing, interrupt arbitration and counters.
// Latency: rdata, csr_illegal and redirect are combinational; CSR updates land at the next clk edge.
// Backpressure: none; every access, trap or mret completes in the cycle it is presented.
`timescale 1ns/1ps
module csr_mtrap_file #(
   parameter int               MXLEN     = 64,
   parameter int               HPM_NUM   = 2,
   parameter bit               VECTORED  = 1'b1,
   parameter logic [MXLEN-1:0] RESET_VEC = 'h8000_0000
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [11:0]                             csr_addr,
   input  logic                                    csr_rena,
   input  logic                                    csr_wena,
   input  logic [1:0]                              csr_op,
   input  logic [MXLEN-1:0]                        csr_wdata,
   output logic [MXLEN-1:0]                        csr_rdata,
   output logic                                    csr_illegal,
   input  logic                                    instr_retire,
   input  logic [((HPM_NUM > 0) ? HPM_NUM : 1)-1:0] hpm_event,
   input  logic                                    time_irq,
   input  logic                                    soft_irq,
   input  logic                                    ext_irq,
   output logic                                    irq_pending,
   output logic [4:0]                              irq_cause,
   input  logic                                    trap_valid,
   input  logic [4:0]                              trap_cause,
   input  logic [MXLEN-1:0]                        trap_epc,
   input  logic [MXLEN-1:0]                        trap_tval,
   input  logic                                    mret,
   output logic                                    redirect_valid,
   output logic [MXLEN-1:0]                        redirect_pc
);

   localparam int HW = (HPM_NUM > 0) ? HPM_NUM : 1;
   localparam logic [1:0] CSR_RW = 2'b01;
   localparam logic [1:0] CSR_RS = 2'b10;
   localparam logic [1:0] CSR_RC = 2'b11;
   // mie keeps only MSIE/MTIE/MEIE; mcountinhibit keeps CY, IR and the implemented HPM bits
   localparam logic [MXLEN-1:0] MIE_MASK = MXLEN'(64'h888);
   localparam logic [MXLEN-1:0] INH_MASK = MXLEN'(((64'd1 << (3 + HPM_NUM)) - 64'd1) & ~64'h2);

   logic             mstatus_mie, mstatus_mpie;
   logic [MXLEN-1:0] mie_q, mcountinhibit_q, mscratch_q, mepc_q, mcause_q, mtval_q;
   logic [MXLEN-3:0] mtvec_base;
   logic [1:0]       mtvec_mode;
   logic             msip_q, mtip_q, meip_q;
   logic [MXLEN-1:0] mcycle_q, minstret_q;
   logic [MXLEN-1:0] hpm_q [HW];
   logic [MXLEN-1:0] mstatus_val, mip_val, old_val, new_val;
   logic             mapped, wr_ok;

   // Architectural views of the packed status registers
   always_comb begin
      mstatus_val        = '0;
      mstatus_val[3]     = mstatus_mie;
      mstatus_val[7]     = mstatus_mpie;
      mstatus_val[12:11] = 2'b11;
      mip_val            = '0;
      mip_val[3]         = msip_q;
      mip_val[7]         = mtip_q;
      mip_val[11]        = meip_q;
   end

   // Address decode and read mux; unmapped addresses read as zero
   always_comb begin
      mapped  = 1'b1;
      old_val = '0;
      case (csr_addr)
         12'h300: old_val = mstatus_val;
         12'h304: old_val = mie_q;
         12'h305: old_val = {mtvec_base, mtvec_mode};
         12'h320: old_val = mcountinhibit_q;
         12'h340: old_val = mscratch_q;
         12'h341: old_val = mepc_q;
         12'h342: old_val = mcause_q;
         12'h343: old_val = mtval_q;
         12'h344: old_val = mip_val;
         12'hB00, 12'hC00: old_val = mcycle_q;
         12'hB02, 12'hC02: old_val = minstret_q;
         12'hF14: old_val = '0;
         default: begin
            mapped = 1'b0;
            for (int i = 0; i < HPM_NUM; i++) begin
               if (csr_addr == 12'(12'hB03 + i) || csr_addr == 12'(12'hC03 + i)) begin
                  mapped  = 1'b1;
                  old_val = hpm_q[i];
               end
            end
         end
      endcase
   end

   // Writes to the 0xC00-0xFFF read-only quadrant are rejected like unmapped addresses
   assign csr_illegal = (csr_rena | csr_wena) & (~mapped | (csr_wena & (csr_addr[11:10] == 2'b11)));
   assign csr_rdata   = (csr_rena & ~csr_illegal) ? old_val : '0;
   // Trap and mret own the cycle; a CSR write presented alongside them is dropped
   assign wr_ok       = csr_wena & ~csr_illegal & ~trap_valid & ~mret;

   // Read-modify-write operand for the selected CSR
   always_comb begin
      case (csr_op)
         CSR_RW:  new_val = csr_wdata;
         CSR_RS:  new_val = old_val | csr_wdata;
         CSR_RC:  new_val = old_val & ~csr_wdata;
         default: new_val = csr_wdata;
      endcase
   end

   // Trap entry, mret and the writable trap-control CSRs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mstatus_mie     <= 1'b0;
         mstatus_mpie    <= 1'b0;
         mie_q           <= '0;
         mtvec_base      <= RESET_VEC[MXLEN-1:2];
         mtvec_mode      <= RESET_VEC[1:0];
         mcountinhibit_q <= '0;
         mscratch_q      <= '0;
         mepc_q          <= '0;
         mcause_q        <= '0;
         mtval_q         <= '0;
      end else if (trap_valid) begin
         mepc_q       <= {trap_epc[MXLEN-1:2], 2'b00};
         mcause_q     <= {trap_cause[4], {(MXLEN-5){1'b0}}, trap_cause[3:0]};
         mtval_q      <= trap_tval;
         mstatus_mpie <= mstatus_mie;
         mstatus_mie  <= 1'b0;
      end else if (mret) begin
         mstatus_mie  <= mstatus_mpie;
         mstatus_mpie <= 1'b1;
      end else if (wr_ok) begin
         case (csr_addr)
            12'h300: begin
               mstatus_mie  <= new_val[3];
               mstatus_mpie <= new_val[7];
            end
            12'h304: mie_q <= new_val & MIE_MASK;
            12'h305: begin
               mtvec_base <= new_val[MXLEN-1:2];
               // Reserved modes, or vectored when not supported, leave the mode as it was
               if (new_val[1:0] == 2'b00 || (VECTORED && new_val[1:0] == 2'b01))
                  mtvec_mode <= new_val[1:0];
            end
            12'h320: mcountinhibit_q <= new_val & INH_MASK;
            12'h340: mscratch_q      <= new_val;
            12'h341: mepc_q          <= {new_val[MXLEN-1:2], 2'b00};
            12'h342: mcause_q        <= new_val;
            12'h343: mtval_q         <= new_val;
            default: ;
         endcase
      end
   end

   // mcycle / minstret: a CSR write wins over that cycle's increment
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         if (wr_ok && csr_addr == 12'hB00)
            mcycle_q <= new_val;
         else if (!mcountinhibit_q[0])
            mcycle_q <= mcycle_q + MXLEN'(1);
         if (wr_ok && csr_addr == 12'hB02)
            minstret_q <= new_val;
         else if (instr_retire && !mcountinhibit_q[2])
            minstret_q <= minstret_q + MXLEN'(1);
      end
   end

   genvar g;
   generate
      for (g = 0; g < HPM_NUM; g++) begin : g_hpm
         // Event counter g, inhibited by mcountinhibit[3+g]
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               hpm_q[g] <= '0;
            else if (wr_ok && csr_addr == 12'(12'hB03 + g))
               hpm_q[g] <= new_val;
            else if (hpm_event[g] && !mcountinhibit_q[3+g])
               hpm_q[g] <= hpm_q[g] + MXLEN'(1);
         end
      end
      if (HPM_NUM == 0) begin : g_no_hpm
         assign hpm_q[0] = '0;
      end
   endgenerate

   // Sample interrupt lines, then arbitrate MEI > MSI > MTI one cycle later
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         msip_q      <= 1'b0;
         mtip_q      <= 1'b0;
         meip_q      <= 1'b0;
         irq_pending <= 1'b0;
         irq_cause   <= '0;
      end else begin
         msip_q      <= soft_irq;
         mtip_q      <= time_irq;
         meip_q      <= ext_irq;
         irq_pending <= mstatus_mie & (|(mip_val & mie_q));
         if (!mstatus_mie)
            irq_cause <= '0;
         else if (meip_q && mie_q[11])
            irq_cause <= 5'h1B;
         else if (msip_q && mie_q[3])
            irq_cause <= 5'h13;
         else if (mtip_q && mie_q[7])
            irq_cause <= 5'h17;
         else
            irq_cause <= '0;
      end
   end

   assign redirect_valid = trap_valid | mret;

   // Redirect target: vectored interrupts land at base + 4*code, everything else at base; mret at mepc
   always_comb begin
      redirect_pc = '0;
      if (trap_valid) begin
         if (mtvec_mode == 2'b01 && trap_cause[4])
            redirect_pc = {mtvec_base, 2'b00} + MXLEN'({trap_cause[3:0], 2'b00});
         else
            redirect_pc = {mtvec_base, 2'b00};
      end else if (mret) begin
         redirect_pc = mepc_q;
      end
   end

endmodule

// File: tb/tb_csr_mtrap_file.sv
`timescale 1ns/1ps
module tb_csr_mtrap_file;
   localparam logic [63:0] RV    = 64'h8000_0000;
   localparam logic [1:0]  OP_RW = 2'b01;
   localparam logic [1:0]  OP_RS = 2'b10;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] csr_addr;
   logic        csr_rena, csr_wena;
   logic [1:0]  csr_op;
   logic [63:0] csr_wdata, csr_rdata;
   logic        csr_illegal, instr_retire;
   logic [1:0]  hpm_event;
   logic        time_irq, soft_irq, ext_irq, irq_pending;
   logic [4:0]  irq_cause;
   logic        trap_valid;
   logic [4:0]  trap_cause;
   logic [63:0] trap_epc, trap_tval;
   logic        mret, redirect_valid;
   logic [63:0] redirect_pc;

   always #5 clk = ~clk;

   csr_mtrap_file #(.MXLEN(64), .HPM_NUM(2), .VECTORED(1'b1), .RESET_VEC(64'h8000_0000)) dut (
      .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_rena(csr_rena), .csr_wena(csr_wena),
      .csr_op(csr_op), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
      .instr_retire(instr_retire), .hpm_event(hpm_event), .time_irq(time_irq), .soft_irq(soft_irq),
      .ext_irq(ext_irq), .irq_pending(irq_pending), .irq_cause(irq_cause), .trap_valid(trap_valid),
      .trap_cause(trap_cause), .trap_epc(trap_epc), .trap_tval(trap_tval), .mret(mret),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc));

   // ---------------- scoreboard ----------------
   typedef enum int {K_RDATA, K_ILL, K_RV, K_RPC, K_PEND, K_CAUSE} kind_t;
   typedef struct {
      kind_t       kind;
      logic [63:0] exp;
      int          stamp;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input kind_t k, input logic [63:0] v, input string n);
      exp_t e;
      e.kind = k; e.exp = v; e.stamp = cyc; e.name = n;
      sb.push_back(e);
   endtask

   // Monitor: compare everything expected for this cycle on the falling edge
   always @(negedge clk) begin
      exp_t        e;
      logic [63:0] act;
      while (sb.size() > 0 && sb[0].stamp <= cyc) begin
         e = sb.pop_front();
         case (e.kind)
            K_RDATA: act = csr_rdata;
            K_ILL:   act = 64'(csr_illegal);
            K_RV:    act = 64'(redirect_valid);
            K_RPC:   act = redirect_pc;
            K_PEND:  act = 64'(irq_pending);
            default: act = 64'(irq_cause);
         endcase
         vectors++;
         if (e.stamp != cyc) begin
            miscompares++;
            $display("FAIL %s stale expectation from cycle %0d seen at cycle %0d", e.name, e.stamp, cyc);
         end else if (act !== e.exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", e.name, cyc, act, e.exp);
         end
      end
   end

   // ---------------- reference model ----------------
   bit          m_mie_b, m_mpie, m_msi, m_mti, m_mei, m_pend;
   logic [4:0]  m_cause;
   logic [63:0] m_mie, m_mtvec, m_minh, m_mscr, m_mepc, m_mcause, m_mtval, m_cyc, m_ins;
   logic [63:0] m_hpm [2];

   task automatic model_reset();
      m_mie_b = 0; m_mpie = 0; m_msi = 0; m_mti = 0; m_mei = 0; m_pend = 0; m_cause = '0;
      m_mie = '0; m_mtvec = RV; m_minh = '0; m_mscr = '0; m_mepc = '0; m_mcause = '0;
      m_mtval = '0; m_cyc = '0; m_ins = '0; m_hpm[0] = '0; m_hpm[1] = '0;
   endtask

   function automatic bit m_read(input logic [11:0] a, output logic [63:0] v);
      v = '0;
      m_read = 1'b1;
      case (a)
         12'h300: v = 64'h1800 | (64'(m_mie_b) << 3) | (64'(m_mpie) << 7);
         12'h304: v = m_mie;
         12'h305: v = m_mtvec;
         12'h320: v = m_minh;
         12'h340: v = m_mscr;
         12'h341: v = m_mepc;
         12'h342: v = m_mcause;
         12'h343: v = m_mtval;
         12'h344: v = {52'b0, m_mei, 3'b0, m_mti, 3'b0, m_msi, 3'b0};
         12'hB00, 12'hC00: v = m_cyc;
         12'hB02, 12'hC02: v = m_ins;
         12'hB03, 12'hC03: v = m_hpm[0];
         12'hB04, 12'hC04: v = m_hpm[1];
         12'hF14: v = '0;
         default: m_read = 1'b0;
      endcase
   endfunction

   task automatic m_write(input logic [11:0] a, input logic [63:0] nv);
      case (a)
         12'h300: begin m_mie_b = nv[3]; m_mpie = nv[7]; end
         12'h304: m_mie = nv & 64'h888;
         12'h305: m_mtvec = {nv[63:2], (nv[1:0] <= 2'b01) ? nv[1:0] : m_mtvec[1:0]};
         12'h320: m_minh = nv & 64'h1D;
         12'h340: m_mscr = nv;
         12'h341: m_mepc = nv & ~64'h3;
         12'h342: m_mcause = nv;
         12'h343: m_mtval = nv;
         12'hB00: m_cyc = nv;
         12'hB02: m_ins = nv;
         12'hB03: m_hpm[0] = nv;
         12'hB04: m_hpm[1] = nv;
         default: ;
      endcase
   endtask

   // State change at a clock edge, using the inputs presented during that cycle
   task automatic m_edge(input logic [63:0] nv, input bit legal_wr);
      bit         e_mei, e_msi, e_mti, np;
      logic [4:0] nc;
      e_mei = m_mei & m_mie[11];
      e_msi = m_msi & m_mie[3];
      e_mti = m_mti & m_mie[7];
      np = m_mie_b & (e_mei | e_msi | e_mti);
      nc = !np ? 5'h00 : e_mei ? 5'h1B : e_msi ? 5'h13 : 5'h17;
      if (!m_minh[0]) m_cyc = m_cyc + 1;
      if (!m_minh[2] && instr_retire) m_ins = m_ins + 1;
      for (int i = 0; i < 2; i++)
         if (!m_minh[3+i] && hpm_event[i]) m_hpm[i] = m_hpm[i] + 1;
      if (trap_valid) begin
         m_mepc   = trap_epc & ~64'h3;
         m_mcause = {trap_cause[4], 59'b0, trap_cause[3:0]};
         m_mtval  = trap_tval;
         m_mpie   = m_mie_b;
         m_mie_b  = 0;
      end else if (mret) begin
         m_mie_b = m_mpie;
         m_mpie  = 1;
      end else if (legal_wr) begin
         m_write(csr_addr, nv);
      end
      m_pend = np; m_cause = nc;
      m_msi = soft_irq; m_mti = time_irq; m_mei = ext_irq;
   endtask

   // ---------------- stimulus ----------------
   task automatic idle();
      csr_rena = 0; csr_wena = 0; trap_valid = 0; mret = 0; instr_retire = 0; hpm_event = '0;
   endtask

   task automatic set_csr(input logic [11:0] a, input bit r, input bit w, input logic [1:0] op,
                          input logic [63:0] d);
      csr_addr = a; csr_rena = r; csr_wena = w; csr_op = op; csr_wdata = d;
   endtask

   // One cycle: queue expectations from the model, clock, advance the model
   task automatic tick();
      logic [63:0] v, nv, base;
      bit          mp, ill;
      mp  = m_read(csr_addr, v);
      ill = (csr_rena || csr_wena) && (!mp || (csr_wena && csr_addr[11:10] == 2'b11));
      if (csr_rena) push(K_RDATA, ill ? 64'h0 : v, "rdata");
      push(K_ILL, 64'(ill), "illegal");
      push(K_RV, 64'(trap_valid | mret), "redirect_valid");
      base = {m_mtvec[63:2], 2'b00};
      if (trap_valid)
         push(K_RPC, (m_mtvec[1:0] == 2'b01 && trap_cause[4]) ? base + 64'(trap_cause[3:0]) * 4 : base,
              "redirect_pc_trap");
      else if (mret)
         push(K_RPC, m_mepc, "redirect_pc_mret");
      push(K_PEND, 64'(m_pend), "irq_pending");
      push(K_CAUSE, 64'(m_cause), "irq_cause");
      case (csr_op)
         2'b10:   nv = v | csr_wdata;
         2'b11:   nv = v & ~csr_wdata;
         default: nv = csr_wdata;
      endcase
      @(posedge clk);
      if (rst) m_edge(nv, csr_wena && !ill);
      else     model_reset();
      #1;
      idle();
   endtask

   logic [11:0] alist [21] = '{12'h300, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341, 12'h342,
                               12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB03, 12'hB04, 12'hC00,
                               12'hC02, 12'hC03, 12'hC04, 12'hF14, 12'h7FF, 12'hB05, 12'h123};

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] ins0;
      rst = 0; idle(); set_csr(12'h000, 0, 0, OP_RW, '0);
      time_irq = 0; soft_irq = 0; ext_irq = 0;
      trap_cause = '0; trap_epc = '0; trap_tval = '0;
      model_reset();
      @(posedge clk); #1;

      // reset state
      set_csr(12'h305, 1, 0, OP_RW, '0); push(K_RDATA, RV, "reset_mtvec"); tick();
      set_csr(12'h300, 1, 0, OP_RW, '0); push(K_RDATA, 64'h1800, "reset_mstatus"); tick();
      rst = 1;
      for (int k = 0; k < 3; k++) begin
         set_csr(12'hB00, 1, 0, OP_RW, '0); push(K_RDATA, 64'(k), "mcycle_count"); tick();
      end

      // interrupt arbitration: MEI beats MTI, visible two clocks after the lines rise
      set_csr(12'h304, 0, 1, OP_RW, 64'h888); tick();
      set_csr(12'h300, 0, 1, OP_RS, 64'h8); tick();
      ext_irq = 1; time_irq = 1; tick();
      tick();
      push(K_PEND, 64'h1, "irq_pending_2clk"); push(K_CAUSE, 64'h1B, "irq_cause_mei"); tick();

      // vectored trap entry
      set_csr(12'h305, 0, 1, OP_RW, 64'h1001); tick();
      trap_valid = 1; trap_cause = 5'h17; trap_epc = 64'h80; trap_tval = 64'h1234;
      push(K_RPC, 64'h101C, "trap_vector_pc"); tick();
      set_csr(12'h341, 1, 0, OP_RW, '0); push(K_RDATA, 64'h80, "trap_mepc"); tick();
      set_csr(12'h300, 1, 0, OP_RW, '0); push(K_RDATA, 64'h1880, "trap_mstatus"); tick();
      set_csr(12'h342, 1, 0, OP_RW, '0); push(K_RDATA, 64'h8000_0000_0000_0007, "trap_mcause"); tick();

      // mret, then trap and mret together
      mret = 1; push(K_RPC, 64'h80, "mret_pc"); tick();
      set_csr(12'h300, 1, 0, OP_RW, '0); push(K_RDATA, 64'h1888, "mret_mstatus"); tick();
      trap_valid = 1; mret = 1; trap_cause = 5'h17; trap_epc = 64'h200;
      push(K_RPC, 64'h101C, "trap_over_mret"); tick();
      set_csr(12'h300, 1, 0, OP_RW, '0); push(K_RDATA, 64'h1880, "trap_over_mret_mstatus"); tick();
      set_csr(12'h341, 1, 0, OP_RW, '0); push(K_RDATA, 64'h200, "trap_over_mret_mepc"); tick();

      // counter inhibit and wrap
      set_csr(12'h320, 0, 1, OP_RW, 64'h4); tick();
      ins0 = m_ins;
      for (int k = 0; k < 5; k++) begin
         set_csr(12'hB02, 1, 0, OP_RW, '0); instr_retire = 1;
         push(K_RDATA, ins0, "minstret_inhibited"); tick();
      end
      set_csr(12'hB00, 0, 1, OP_RW, '1); tick();
      set_csr(12'hB00, 1, 0, OP_RW, '0); push(K_RDATA, '1, "mcycle_all_ones"); tick();
      set_csr(12'hB00, 1, 0, OP_RW, '0); push(K_RDATA, 64'h0, "mcycle_wrap"); tick();

      // illegal accesses and WARL mtvec mode
      set_csr(12'hC00, 1, 1, OP_RW, 64'h55);
      push(K_ILL, 64'h1, "write_ro_illegal"); push(K_RDATA, 64'h0, "write_ro_rdata"); tick();
      set_csr(12'h7FF, 1, 1, OP_RW, 64'h55);
      push(K_ILL, 64'h1, "unmapped_illegal"); push(K_RDATA, 64'h0, "unmapped_rdata"); tick();
      set_csr(12'h305, 0, 1, OP_RW, 64'h2003); tick();
      set_csr(12'h305, 1, 0, OP_RW, '0); push(K_RDATA, 64'h2001, "mtvec_warl_mode"); tick();

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         set_csr(alist[$urandom_range(0, 20)], ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 3),
                 2'($urandom_range(1, 3)),
                 ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 4095)));
         trap_valid   = ($urandom_range(0, 19) == 0);
         mret         = ($urandom_range(0, 19) == 0);
         trap_cause   = 5'($urandom);
         trap_epc     = {$urandom, $urandom};
         trap_tval    = {$urandom, $urandom};
         instr_retire = 1'($urandom);
         hpm_event    = 2'($urandom);
         if ($urandom_range(0, 7) == 0) {ext_irq, time_irq, soft_irq} = 3'($urandom);
         tick();
      end

      // reset asserted mid-operation
      rst = 0; model_reset();
      set_csr(12'h305, 1, 0, OP_RW, '0); push(K_RDATA, RV, "midrst_mtvec");
      push(K_PEND, 64'h0, "midrst_pending"); push(K_CAUSE, 64'h0, "midrst_cause"); tick();
      tick();
      rst = 1;
      set_csr(12'hB00, 1, 0, OP_RW, '0); push(K_RDATA, 64'h0, "midrst_mcycle"); tick();
      set_csr(12'h300, 1, 0, OP_RW, '0); push(K_RDATA, 64'h1800, "midrst_mstatus"); tick();

      @(negedge clk); #1;
      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
